// File: rtl/pipe_generator.sv
// Scrolling obstacle pipe with random gap height, pass-the-bird scoring
// and the game-level IDLE/RUN/OVER control that freezes play on collision.
module pipe_generator #(
    parameter int          WIDTH      = 10,
    parameter int          HEIGHT     = 10,
    parameter int          SCREEN_W   = 640,
    parameter int          SCREEN_H   = 480,
    parameter int          PIPE_WIDTH = 40,
    parameter int          GAP_HEIGHT = 120,
    parameter int          GAP_MARGIN = 40,
    parameter int          SPEED      = 2,
    parameter int          BIRD_X     = 100,
    parameter int          SCORE_W    = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               collision_in,
    output logic [WIDTH-1:0]   pipe_x,
    output logic [HEIGHT-1:0]  pipe_y,
    output logic               pipe_valid,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [WIDTH-1:0]  START_X   = WIDTH'(SCREEN_W);
    localparam logic [HEIGHT-1:0] START_Y   = HEIGHT'((SCREEN_H - GAP_HEIGHT) / 2);
    localparam logic [HEIGHT-1:0] MARGIN_Y  = HEIGHT'(GAP_MARGIN);
    localparam logic [WIDTH-1:0]  SPEED_X   = WIDTH'(SPEED);
    localparam logic [WIDTH:0]    PIPE_W_X  = (WIDTH+1)'(PIPE_WIDTH);
    localparam logic [WIDTH:0]    BIRD_X_X  = (WIDTH+1)'(BIRD_X);
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [15:0]        lfsr;
    logic               scored;
    logic               respawn;
    logic               move_en;
    logic               load_en;
    logic               passed_bird;
    logic [WIDTH-1:0]   new_x;
    logic [WIDTH:0]     pipe_right;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Collision has priority in RUN, so a same-cycle start cannot restart the game.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start)        next_state = RUN;
            RUN:  if (collision_in) next_state = OVER;
            OVER: if (start)        next_state = RUN;
            default:                next_state = IDLE;
        endcase
    end

    always_comb begin
        pipe_valid = 1'b0;
        game_over  = 1'b0;
        case (state)
            RUN:  pipe_valid = 1'b1;
            OVER: begin
                pipe_valid = 1'b1;
                game_over  = 1'b1;
            end
            default: ;
        endcase
    end

    // The right-edge sum needs one extra bit so it never wraps below BIRD_X.
    always_comb begin
        respawn     = (pipe_x < SPEED_X);
        new_x       = respawn ? START_X : (pipe_x - SPEED_X);
        pipe_right  = {1'b0, new_x} + PIPE_W_X;
        passed_bird = (pipe_right < BIRD_X_X);
        move_en     = (state == RUN) && tick && !collision_in;
        load_en     = (state == IDLE) || ((state == OVER) && start);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_x <= START_X;
            pipe_y <= START_Y;
            score  <= '0;
            scored <= 1'b0;
        end else if (load_en) begin
            pipe_x <= START_X;
            pipe_y <= START_Y;
            score  <= '0;
            scored <= 1'b0;
        end else if (move_en) begin
            pipe_x <= new_x;
            if (respawn) begin
                pipe_y <= MARGIN_Y + HEIGHT'(lfsr[7:0]);
            end
            if ((!scored || respawn) && passed_bird) begin
                scored <= 1'b1;
                if (score != {SCORE_W{1'b1}}) begin
                    score <= score + 1'b1;
                end
            end else if (respawn) begin
                scored <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_generator.sv
// Directed, table-driven bench for pipe_generator; a second instance with a
// 2-bit score exercises saturation on the same stimulus.
module tb_pipe_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        collision_in = 1'b0;
    logic [9:0]  pipe_x, pipe_x2;
    logic [9:0]  pipe_y, pipe_y2;
    logic        pipe_valid, pipe_valid2;
    logic [7:0]  score;
    logic [1:0]  score2;
    logic        game_over, game_over2;

    logic [15:0] m_lfsr;
    logic [15:0] lfsr_cap;
    int          pass_count = 0;
    int          check_count = 0;

    typedef struct {
        string name;
        logic  rst;
        logic  st;
        logic  tk;
        logic  col;
        int    cycles;
        int    x;
        int    y;
        bit    chk_y;
        int    score;
        bit    valid;
        bit    over;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    pipe_generator dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .collision_in(collision_in), .pipe_x(pipe_x), .pipe_y(pipe_y),
        .pipe_valid(pipe_valid), .score(score), .game_over(game_over)
    );

    pipe_generator #(.SCORE_W(2)) dut_sat (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .collision_in(collision_in), .pipe_x(pipe_x2), .pipe_y(pipe_y2),
        .pipe_valid(pipe_valid2), .score(score2), .game_over(game_over2)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR for x^16+x^14+x^13+x^11+1, held at the seed in reset.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string name, input int act, input int exp);
        check_count++;
        if (act == exp) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic runCycles(input logic r, input logic s, input logic t,
                             input logic c, input int n);
        reset = r; start = s; tick = t; collision_in = c;
        for (int i = 0; i < n; i++) begin
            lfsr_cap = m_lfsr;
            @(posedge clk);
            #1;
        end
        reset = 1'b0; start = 1'b0; tick = 1'b0; collision_in = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        runCycles(v.rst, v.st, v.tk, v.col, v.cycles);
    endtask

    task automatic checkOutput(input string name, input int x, input int y,
                               input bit chk_y, input int sc, input bit valid,
                               input bit over);
        check({name, ".pipe_x"}, int'(pipe_x), x);
        if (chk_y) check({name, ".pipe_y"}, int'(pipe_y), y);
        check({name, ".score"}, int'(score), sc);
        check({name, ".pipe_valid"}, int'(pipe_valid), int'(valid));
        check({name, ".game_over"}, int'(game_over), int'(over));
    endtask

    initial begin
        int exp_y;

        vecs_a.push_back('{"reset_hold_start", 1, 1, 0, 0,   2, 640, 180, 1, 0, 0, 0});
        vecs_a.push_back('{"idle_after_reset", 0, 0, 0, 0,   1, 640, 180, 1, 0, 0, 0});
        vecs_a.push_back('{"idle_ticks",       0, 0, 1, 0,   3, 640, 180, 1, 0, 0, 0});
        vecs_a.push_back('{"start",            0, 1, 0, 0,   1, 640, 180, 1, 0, 1, 0});
        vecs_a.push_back('{"tick5",            0, 0, 1, 0,   5, 630, 180, 1, 0, 1, 0});
        vecs_a.push_back('{"tick290",          0, 0, 1, 0, 285,  60, 180, 1, 0, 1, 0});
        vecs_a.push_back('{"tick291",          0, 0, 1, 0,   1,  58, 180, 1, 1, 1, 0});
        vecs_a.push_back('{"tick320",          0, 0, 1, 0,  29,   0, 180, 1, 1, 1, 0});

        vecs_b.push_back('{"to400",            0, 0, 1, 0, 120, 400,   0, 0, 1, 1, 0});
        vecs_b.push_back('{"collide_tick",     0, 0, 1, 1,   1, 400,   0, 0, 1, 1, 1});
        vecs_b.push_back('{"over_ticks",       0, 0, 1, 0,  10, 400,   0, 0, 1, 1, 1});
        vecs_b.push_back('{"over_collide",     0, 0, 0, 1,   2, 400,   0, 0, 1, 1, 1});
        vecs_b.push_back('{"restart",          0, 1, 0, 0,   1, 640, 180, 1, 0, 1, 0});
        vecs_b.push_back('{"tick10",           0, 0, 1, 0,  10, 620, 180, 1, 0, 1, 0});
        vecs_b.push_back('{"start_in_run",     0, 1, 0, 0,   1, 620, 180, 1, 0, 1, 0});
        vecs_b.push_back('{"start_vs_collide", 0, 1, 0, 1,   1, 620, 180, 1, 0, 1, 1});
        vecs_b.push_back('{"restart2",         0, 1, 0, 0,   1, 640, 180, 1, 0, 1, 0});

        foreach (vecs_a[i]) begin
            applyStimulus(vecs_a[i]);
            checkOutput(vecs_a[i].name, vecs_a[i].x, vecs_a[i].y, vecs_a[i].chk_y,
                        vecs_a[i].score, vecs_a[i].valid, vecs_a[i].over);
        end

        // Respawn tick: gap top comes from the LFSR value of the tick cycle.
        runCycles(0, 0, 1, 0, 1);
        exp_y = 40 + int'(lfsr_cap[7:0]);
        checkOutput("respawn", 640, exp_y, 1, 1, 1, 0);
        check("respawn.y_in_range", int'(pipe_y >= 10'd40 && pipe_y <= 10'd295), 1);

        foreach (vecs_b[i]) begin
            applyStimulus(vecs_b[i]);
            checkOutput(vecs_b[i].name, vecs_b[i].x, vecs_b[i].y, vecs_b[i].chk_y,
                        vecs_b[i].score, vecs_b[i].valid, vecs_b[i].over);
        end

        // Five full pipes: the 2-bit score saturates at 3.
        runCycles(1, 0, 0, 0, 2);
        runCycles(0, 1, 0, 0, 1);
        check("sat.start.score2", int'(score2), 0);
        for (int k = 1; k <= 5; k++) begin
            runCycles(0, 0, 1, 0, 321);
            check($sformatf("sat%0d.score2", k), int'(score2), (k > 3) ? 3 : k);
            check($sformatf("sat%0d.score", k), int'(score), k);
            check($sformatf("sat%0d.pipe_x2", k), int'(pipe_x2), 640);
        end

        // Reset in the middle of a game.
        runCycles(1, 0, 0, 0, 2);
        runCycles(0, 1, 0, 0, 1);
        runCycles(0, 0, 1, 0, 862);
        checkOutput("mid_run", 200, 0, 0, 2, 1, 0);
        runCycles(1, 0, 0, 0, 1);
        checkOutput("mid_reset", 640, 180, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
